// File: rtl/capture_seq_pkg.sv
// Shared types and helpers for the multi-frame capture sequencer.
package capture_seq_pkg;

    // Sequencer states; the encoding is visible on the debug state output.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHECK     = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_VERIFY    = 3'd5,
        S_GAP       = 3'd6,
        S_FINISH    = 3'd7
    } seq_state_t;

    // Camera select encoding driven on camera_sel.
    localparam logic CAM_HAWK = 1'b0;
    localparam logic CAM_OWL  = 1'b1;

    // DMA beats one frame should produce: pixel count scaled down by the
    // number of pixels packed into each beat.
    function automatic logic [31:0] expected_beats(
        input logic [15:0] w,
        input logic [15:0] h,
        input int          shift
    );
        logic [31:0] prod;
        prod = 32'(w) * 32'(h);
        return prod >> shift;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by every wait state of the sequencer.
// A loaded value N reaches zero after N counting cycles; zero means expired.
module seq_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] value,
    output logic             expired
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // Load takes priority; otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - ONE;
        end
    end

    assign expired = (value == '0);

endmodule

// File: rtl/capture_sequencer.sv
// Multi-frame Hawk/Owl capture scheduler. One start issues a programmed
// series of captures, alternating cameras, watching the receiver handshake,
// enforcing timeouts and checking the DMA beat count of every frame.
//
// Receiver handshake: new_capture is a one-cycle request qualified by
// camera_sel. The receiver acknowledges by raising camera_in_progress and
// signals frame completion by dropping it again; both levels are sampled
// on sys_clk with no further qualification.
module capture_sequencer
    import capture_seq_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int FRM_W     = 8,
    parameter int PIX_SHIFT = 3
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic             abort,
    input  logic [FRM_W-1:0] hawk_frames,
    input  logic [FRM_W-1:0] owl_frames,
    input  logic [15:0]      hawk_image_width,
    input  logic [15:0]      hawk_image_height,
    input  logic [15:0]      owl_image_width,
    input  logic [15:0]      owl_image_height,
    input  logic [CNT_W-1:0] interval,
    input  logic [CNT_W-1:0] ack_timeout,
    input  logic [CNT_W-1:0] frame_timeout,
    input  logic             serde_locked,
    input  logic             camera_in_progress,
    input  logic [CNT_W-1:0] dma_cnt,
    output logic             new_capture,
    output logic             camera_sel,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic             err_count,
    output logic             err_unlocked,
    output logic [15:0]      frames_done,
    output logic [2:0]       state_dbg
);

    localparam logic [FRM_W-1:0] FRM_ONE = FRM_W'(1);

    seq_state_t       state;
    logic [FRM_W-1:0] hawk_left;
    logic [FRM_W-1:0] owl_left;
    logic             next_cam;
    logic [CNT_W-1:0] dma_snap;

    logic             timer_load;
    logic [CNT_W-1:0] timer_load_value;
    logic [CNT_W-1:0] timer_value;
    logic             timer_expired;

    logic [31:0]      beats_raw;
    logic [CNT_W-1:0] beats_exp;
    logic [CNT_W-1:0] dma_delta;
    logic             abort_now;

    assign state_dbg = state;

    // Expected beats for the camera currently being captured; the delta is
    // taken modulo 2^CNT_W so a wrapping DMA counter is handled naturally.
    assign beats_raw = (camera_sel == CAM_OWL)
                     ? expected_beats(owl_image_width,  owl_image_height,  PIX_SHIFT)
                     : expected_beats(hawk_image_width, hawk_image_height, PIX_SHIFT);
    assign beats_exp = CNT_W'(beats_raw);
    assign dma_delta = dma_cnt - dma_snap;

    // FINISH and IDLE are the only states that ignore abort.
    assign abort_now = abort && (state != S_IDLE) && (state != S_FINISH);

    // Timer reload points: ack window on issue, frame window on ack, gap after verify.
    always_comb begin
        timer_load       = 1'b0;
        timer_load_value = ack_timeout;
        case (state)
            S_ISSUE: begin
                timer_load       = 1'b1;
                timer_load_value = ack_timeout;
            end
            S_WAIT_ACK: begin
                timer_load       = camera_in_progress;
                timer_load_value = frame_timeout;
            end
            S_VERIFY: begin
                timer_load       = 1'b1;
                timer_load_value = interval;
            end
            default: ;
        endcase
    end

    seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .load       (timer_load),
        .load_value (timer_load_value),
        .value      (timer_value),
        .expired    (timer_expired)
    );

    // Sequencer FSM with registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= S_IDLE;
            new_capture  <= 1'b0;
            camera_sel   <= CAM_HAWK;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_timeout  <= 1'b0;
            err_count    <= 1'b0;
            err_unlocked <= 1'b0;
            frames_done  <= '0;
            hawk_left    <= '0;
            owl_left     <= '0;
            next_cam     <= CAM_HAWK;
            dma_snap     <= '0;
        end else begin
            new_capture <= 1'b0;
            done        <= 1'b0;

            if (abort_now) begin
                // An issue cycle still emits its request: a capture is never retracted.
                if (state == S_ISSUE) begin
                    new_capture <= 1'b1;
                    dma_snap    <= dma_cnt;
                end
                state <= S_FINISH;
                done  <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            hawk_left    <= hawk_frames;
                            owl_left     <= owl_frames;
                            frames_done  <= '0;
                            err_timeout  <= 1'b0;
                            err_count    <= 1'b0;
                            err_unlocked <= 1'b0;
                            next_cam     <= CAM_HAWK;
                            busy         <= 1'b1;
                            state        <= S_CHECK;
                        end
                    end

                    S_CHECK: begin
                        if (hawk_left == '0 && owl_left == '0) begin
                            state <= S_FINISH;
                            done  <= 1'b1;
                        end else if (!serde_locked) begin
                            err_unlocked <= 1'b1;
                            state        <= S_FINISH;
                            done         <= 1'b1;
                        end else begin
                            // Alternate while both cameras have work; otherwise skip the exhausted one.
                            if (hawk_left != '0 && owl_left != '0) begin
                                camera_sel <= next_cam;
                                next_cam   <= ~next_cam;
                            end else if (hawk_left != '0) begin
                                camera_sel <= CAM_HAWK;
                            end else begin
                                camera_sel <= CAM_OWL;
                            end
                            state <= S_ISSUE;
                        end
                    end

                    S_ISSUE: begin
                        new_capture <= 1'b1;
                        dma_snap    <= dma_cnt;
                        state       <= S_WAIT_ACK;
                    end

                    S_WAIT_ACK: begin
                        if (camera_in_progress) begin
                            state <= S_WAIT_DONE;
                        end else if (timer_expired) begin
                            err_timeout <= 1'b1;
                            state       <= S_FINISH;
                            done        <= 1'b1;
                        end
                    end

                    S_WAIT_DONE: begin
                        if (!camera_in_progress) begin
                            state <= S_VERIFY;
                        end else if (timer_expired) begin
                            err_timeout <= 1'b1;
                            state       <= S_FINISH;
                            done        <= 1'b1;
                        end
                    end

                    S_VERIFY: begin
                        // A short or long transfer is flagged but the sequence carries on.
                        if (dma_delta != beats_exp) begin
                            err_count <= 1'b1;
                        end
                        if (camera_sel == CAM_OWL) begin
                            owl_left <= owl_left - FRM_ONE;
                        end else begin
                            hawk_left <= hawk_left - FRM_ONE;
                        end
                        if (frames_done != 16'hFFFF) begin
                            frames_done <= frames_done + 16'd1;
                        end
                        state <= S_GAP;
                    end

                    S_GAP: begin
                        // The gap only needs the remaining count itself.
                        if (timer_value == '0) begin
                            state <= S_CHECK;
                        end
                    end

                    S_FINISH: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end

                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
